// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg : shared state encoding, RW constants and frame-width helper
// Rev 1.0
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// spi_sync_edge : 2-flop synchronizer plus history flop, rise/fall pulses
// Rev 1.0
// ============================================================================
module spi_sync_edge
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic hist_q;

    // Reset to 0 so a cs_n held low through reset never looks like a new frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            hist_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~hist_q;
    assign fall_o  = ~s2_q & hist_q;

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
// spi_reg_bank : oversampled SPI (mode 0) register bank, RW+addr+data frames.
// Read-back on cipo is compiled in only when SPI_READBACK_EN is defined.
// Rev 1.0
// ============================================================================
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         copi,
    output logic                         cipo,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic                         wr_stb,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         addr_err
);

    localparam int                FRAME_W    = frame_w(ADDR_W, DATA_W);
    localparam int                CNT_W      = $clog2(FRAME_W + 1);
    localparam int                CMD_W      = 1 + ADDR_W;
    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;
    logic copi_lvl;
    logic sclk_lvl_unused;
    logic cs_lvl_unused;
    logic copi_rise_unused;
    logic copi_fall_unused;

    spi_sync_edge u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .d_i     (sclk),
        .level_o (sclk_lvl_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .d_i     (cs_n),
        .level_o (cs_lvl_unused),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_sync_edge u_sync_copi (
        .clk     (clk),
        .rst     (rst),
        .d_i     (copi),
        .level_o (copi_lvl),
        .rise_o  (copi_rise_unused),
        .fall_o  (copi_fall_unused)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                addr_err_q, addr_err_d;

    logic [CMD_W-1:0]    cmd_shift;
    logic [DATA_W-1:0]   dat_shift;
    logic [ADDR_W-1:0]   cmd_addr;
    logic                cmd_rw;
    logic                addr_ok;

    assign cmd_shift = {cmd_q[CMD_W-2:0], copi_lvl};
    assign dat_shift = {dat_q[DATA_W-2:0], copi_lvl};
    assign cmd_addr  = cmd_q[ADDR_W-1:0];
    assign cmd_rw    = cmd_q[CMD_W-1];
    assign addr_ok   = ({1'b0, cmd_addr} < NUM_REGS_L);

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                cipo_q, cipo_d;
    logic [DATA_W-1:0]   rd_word;

    // Addresses with no register fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (cmd_shift[ADDR_W-1:0] == ADDR_W'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            cipo_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            cipo_q <= cipo_d;
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        dat_d      = dat_q;
        regs_d     = regs_q;
        wr_stb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        addr_err_d = 1'b0;
`ifdef SPI_READBACK_EN
        rd_d       = rd_q;
        cipo_d     = cipo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    cmd_d   = '0;
                    dat_d   = '0;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    cmd_d = cmd_shift;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CMD_LAST) begin
                        state_d = DATA;
`ifdef SPI_READBACK_EN
                        rd_d = (cmd_shift[CMD_W-1] == RW_READ) ? rd_word : '0;
`endif
                    end
                end
            end
            DATA: begin
                // Abort takes priority even over the final rising edge.
                if (cs_rise) begin
                    state_d = IDLE;
                end else begin
`ifdef SPI_READBACK_EN
                    if (sclk_fall) begin
                        cipo_d = rd_q[DATA_W-1];
                        rd_d   = {rd_q[DATA_W-2:0], 1'b0};
                    end
`endif
                    if (sclk_rise) begin
                        dat_d = dat_shift;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == FRAME_LAST) begin
                            state_d = DONE;
                            if (!addr_ok) begin
                                addr_err_d = 1'b1;
                            end else if (cmd_rw == RW_WRITE) begin
                                wr_stb_d  = 1'b1;
                                wr_addr_d = cmd_addr;
                                for (int k = 0; k < NUM_REGS; k++) begin
                                    if (cmd_addr == ADDR_W'(k)) begin
                                        regs_d[k] = dat_shift;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
        endcase
`ifdef SPI_READBACK_EN
        if (state_d != DATA) begin
            cipo_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            dat_q      <= '0;
            regs_q     <= '{default: '0};
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            dat_q      <= dat_d;
            regs_q     <= regs_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            addr_err_q <= addr_err_d;
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
            assign regs[k*DATA_W +: DATA_W] = regs_q[k];
        end
    endgenerate

    assign wr_stb   = wr_stb_q;
    assign wr_addr  = wr_addr_q;
    assign addr_err = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_bank : scoreboard bench for spi_reg_bank at default parameters
// Rev 1.0
// ============================================================================
module tb_spi_reg_bank;

    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int RW       = NUM_REGS * DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              sclk;
    logic              cs_n;
    logic              copi;
    logic              cipo;
    logic [RW-1:0]     regs;
    logic              wr_stb;
    logic [ADDR_W-1:0] wr_addr;
    logic              addr_err;

    spi_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .copi     (copi),
        .cipo     (cipo),
        .regs     (regs),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_err;
        logic [ADDR_W-1:0] addr;
        logic [RW-1:0]     regs;
    } ev_t;

    ev_t               sb_q[$];
    ev_t               mon_e;
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    logic [DATA_W-1:0] exp_rd;
    int                n_tests = 0;
    int                n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] m_flat();
        logic [RW-1:0] v;
        for (int k = 0; k < NUM_REGS; k++) v[k*DATA_W +: DATA_W] = m_regs[k];
        return v;
    endfunction

    task automatic push_write(input int addr, input logic [DATA_W-1:0] data);
        ev_t e;
        m_regs[addr] = data;
        e.is_err = 1'b0;
        e.addr   = ADDR_W'(addr);
        e.regs   = m_flat();
        sb_q.push_back(e);
    endtask

    task automatic push_err(input int addr);
        ev_t e;
        e.is_err = 1'b1;
        e.addr   = ADDR_W'(addr);
        e.regs   = m_flat();
        sb_q.push_back(e);
    endtask

    // Every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (wr_stb || addr_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {wr_stb, addr_err}, 2'b00);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_kind", {wr_stb, addr_err}, mon_e.is_err ? 2'b01 : 2'b10);
                chk("regs_at_commit", regs, mon_e.regs);
                if (!mon_e.is_err) chk("wr_addr", wr_addr, mon_e.addr);
            end
        end
    end

    task automatic cs_low();
        cs_n = 1'b0;
        #40;
    endtask

    task automatic cs_high();
        #40;
        cs_n = 1'b1;
        #60;
    endtask

    // Bits past the 16th are driven as 1 and must be ignored by the DUT.
    task automatic spi_bits(input logic [15:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            if (i < 16) copi = f[15-i];
            else        copi = 1'b1;
            #40;
            if (i >= 8 && i < 16) chk($sformatf("cipo_bit%0d", 15 - i), cipo, exp_rd[15-i]);
            sclk = 1'b1;
            #40;
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] f, input int nbits);
        cs_low();
        spi_bits(f, 0, nbits - 1);
        cs_high();
    endtask

    initial begin
        for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
        exp_rd = '0;
        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        copi = 1'b0;
        #40;
        rst = 1'b0;
        #10;
        chk("rst_regs", regs, '0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_cipo", cipo, 0);

        push_write(3, 8'h5A);
        frame(16'h835A, 16);
        chk("regs_w3", regs, m_flat());

        push_write(0, 8'h11);
        frame(16'h8011, 16);
        push_write(1, 8'h22);
        frame(16'h8122, 16);
        chk("regs_persist", regs, m_flat());

        push_err(10);
        frame(16'h8AFF, 16);
        chk("regs_oor_write", regs, m_flat());

        cs_low();
        spi_bits(16'h84AA, 0, 9);
        cs_high();
        chk("regs_abort", regs, m_flat());
        push_write(4, 8'hAA);
        frame(16'h84AA, 16);
        chk("regs_after_abort", regs, m_flat());

        push_write(2, 8'hC3);
        frame(16'h82C3, 16);
`ifdef SPI_READBACK_EN
        exp_rd = 8'hC3;
`else
        exp_rd = 8'h00;
`endif
        frame(16'h0200, 16);
        exp_rd = 8'h00;
        chk("cipo_after_read", cipo, 0);
        chk("regs_after_read", regs, m_flat());

        push_err(7);
        frame(16'h0700, 16);
        chk("regs_oor_read", regs, m_flat());

        push_write(1, 8'h55);
        frame(16'h8155, 20);
        chk("regs_extra_bits", regs, m_flat());

        cs_low();
        spi_bits(16'h81FF, 0, 11);
        rst = 1'b1;
        #10;
        rst = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
        #10;
        chk("midrst_regs", regs, '0);
        chk("midrst_wr_stb", wr_stb, 0);
        chk("midrst_addr_err", addr_err, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_cipo", cipo, 0);
        spi_bits(16'h81FF, 12, 15);
        cs_high();
        chk("midrst_tail_ignored", regs, '0);

        push_write(0, 8'h77);
        frame(16'h8077, 16);
        chk("regs_after_midrst", regs, m_flat());

        #200;
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI register-bank peripheral, the next generation of the team's fixed 5×8-bit SPI peripheral. It oversamples `sclk`, `cs_n` and `copi` in the `clk` domain and decodes write and read frames of configurable address and data width. Registers hold their values between frames. Optional read-back is driven on `cipo`. It sits between the top-level SPI pins and the control registers consumed by downstream logic such as PWM and GPIO blocks.

## Interface
Parameters:
- `NUM_REGS`, default 5: number of registers; must be ≤ 2^`ADDR_W`.
- `DATA_W`, default 8: register width in bits.
- `ADDR_W`, default 7: address field width in bits.

Ports:
- `clk`  in  1: system clock; the only clock in the block.
- `rst`  in  1: reset; synchronous, active-high.
- `sclk`  in  1: SPI clock from the controller; asynchronous to `clk`.
- `cs_n`  in  1: SPI chip select, active-low; asynchronous to `clk`.
- `copi`  in  1: controller-out, peripheral-in data; asynchronous to `clk`.
- `cipo`  out  1: peripheral-out, controller-in data (read-back).
- `regs`  out  `NUM_REGS*DATA_W`: flat register bus; register k occupies bits [k*DATA_W +: DATA_W].
- `wr_stb`  out  1: one-cycle pulse when a register is committed.
- `wr_addr`  out  `ADDR_W`: address of the last committed write; valid while `wr_stb` is high.
- `addr_err`  out  1: one-cycle pulse when a complete frame targets an address ≥ `NUM_REGS`.

## Operation
- Frame format, MSB first, in this order:
  - RW bit: 1 = write, 0 = read.
  - `ADDR_W` address bits.
  - `DATA_W` data bits.
- Frame length is FRAME_W = 1+`ADDR_W`+`DATA_W` (16 at the defaults).
- SPI mode 0:
  - `copi` is sampled on rising `sclk`.
  - `cipo` changes on falling `sclk`.
- Input conditioning: `sclk`, `cs_n` and `copi` each pass through 2 synchronizer flops plus 1 history flop. Edges are decoded from the last two stages.
- States:
  - IDLE: on synchronized `cs_n` falling, clear the bit counter and go to CMD.
  - CMD: shift in the RW and address bits. After bit 1+`ADDR_W`, go to DATA. For a read, also load the read shifter with regs[addr], or all-zero if addr ≥ `NUM_REGS`.
  - DATA: shift in `DATA_W` bits. On the last rising edge, go to DONE and commit:
    - Write with addr < `NUM_REGS`: update regs[addr], pulse `wr_stb`, drive `wr_addr`.
    - Write with addr ≥ `NUM_REGS`: no register change; pulse `addr_err`.
    - Read: no register change. Pulse `addr_err` if out of range.
  - DONE: ignore further `sclk` edges. On `cs_n` rising, go to IDLE.
- Abort: `cs_n` rising in CMD or DATA returns to IDLE. Nothing is committed and no pulse is generated.
- The bit counter is `$clog2(FRAME_W+1)` bits wide and never wraps. Extra bits after FRAME_W are dropped in DONE.
- Simultaneous events:
  - `cs_n` rising detected in the same cycle as the final `sclk` rising edge: abort wins, and the frame is not committed.
  - `cs_n` falling in the same cycle as a `sclk` edge: that edge is ignored.
- Reset values:
  - `regs` = 0, `wr_stb` = 0, `addr_err` = 0, `wr_addr` = 0, `cipo` = 0.
  - State = IDLE; shifters and counter = 0.
- A reset asserted mid-frame discards the frame. While `cs_n` stays low after reset, the block stays in IDLE until the next `cs_n` falling edge.

## Timing
- Edge detection: pin to edge-detect cycle E is 2–3 `clk` cycles.
- Commit latency: regs, `wr_stb`, `wr_addr` and `addr_err` update in cycle E+1 after the final rising `sclk` edge is detected.
- `wr_stb` and `addr_err` are exactly 1 `clk` wide.
- SCLK limit: each `sclk` high and low phase must last ≥ 3 `clk` periods.
- `cs_n` setup: `cs_n` must be low ≥ 3 `clk` periods before the first rising `sclk` edge.
- `cipo` timing:
  - The first data bit (MSB) is presented on the falling `sclk` edge that follows the last address bit.
  - It is updated 1 cycle after the falling edge is detected.
  - `cipo` is held at 0 outside DATA.
- Back-to-back frames require `cs_n` to be high for ≥ 3 `clk` periods between them.

## Configuration
- `SPI_READBACK_EN` defined:
  - The read shifter and `cipo` drive are compiled in.
  - Read frames shift out regs[addr] MSB first during DATA.
- `SPI_READBACK_EN` undefined:
  - No read shifter; `cipo` is tied to 0.
  - Read frames are parsed and ignored, except that `addr_err` still pulses for out-of-range addresses.

## Structure
- Package `spi_pkg` holds:
  - The state enum: IDLE, CMD, DATA, DONE.
  - The RW encoding constants.
  - A function `frame_w(addr_w, data_w)`.
- Sub-module `spi_sync_edge`: 3-flop synchronizer with rise and fall pulse outputs. It is instantiated once each for `sclk`, `cs_n` and `copi`; the `copi` instance uses only the level output.

## Test plan
- Write to reg 3: frame 0x835A at defaults → `regs[31:24]`=0x5A, all other registers 0, `wr_stb` high for 1 cycle with `wr_addr`=3.
- Persistence: write 0x8011 then 0x8122 → reg0=0x11 and reg1=0x22 simultaneously.
- Out-of-range write: frame 0x8AFF (addr 10) → `regs` unchanged, `addr_err` pulses once, `wr_stb` stays 0.
- Abort: raise `cs_n` after 10 bits of 0x84AA → reg4 unchanged, no pulses. A following full frame 0x84AA then sets reg4=0xAA.
- Read-back with `SPI_READBACK_EN`: write 0x82C3, then read 0x0200 → `cipo` carries 1,1,0,0,0,0,1,1 on the 8 data rising edges. Without the macro, `cipo` stays 0.
- Reset mid-frame: assert `rst` for 1 cycle after 12 bits of a frame → all outputs 0. The remaining bits are ignored until `cs_n` toggles.
